// File: rtl/cic_decimator_pkg.sv
// Shared defaults and helpers for the CIC decimation filter.
package cic_decimator_pkg;

   localparam int default_bitwidth      = 16;
   localparam int default_n             = 4;
   localparam int default_log2_max_rate = 7;
   localparam int default_acc_width     = default_bitwidth + default_n * default_log2_max_rate;
   localparam int rate_width            = 8;

   // N * ceil(log2(R)); a rate of 0 wraps to 256.
   function automatic int rate_to_shift(input logic [rate_width-1:0] rate, input int n_stages);
      int r;
      int clog;
      r    = (rate == '0) ? (1 << rate_width) : int'(rate);
      clog = 0;
      for (int i = 0; i <= rate_width; i++) begin
         if ((1 << i) < r) clog = i + 1;
      end
      return n_stages * clog;
   endfunction

endpackage

// File: rtl/cic_dec_shifter.sv
// Rate-dependent gain compensation: arithmetic shift of the comb output and slice to bitwidth.
module cic_dec_shifter
   import cic_decimator_pkg::*;
#(
   parameter int bitwidth  = default_bitwidth,
   parameter int N         = default_n,
   parameter int acc_width = default_acc_width
) (
   input  logic [rate_width-1:0] rate,
   input  logic [acc_width-1:0]  acc_value,
   output logic [bitwidth-1:0]   result
);

   localparam int shift_width = $clog2(N * rate_width + 1);

   logic [shift_width-1:0] shift;

   assign shift  = shift_width'(rate_to_shift(rate, N));
   // arithmetic shift floors toward negative infinity; no saturation
   assign result = bitwidth'($signed(acc_value) >>> shift);

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: strobed integrators, down-counter decimation, pipelined combs, gain shift.
module cic_decimator
   import cic_decimator_pkg::*;
#(
   parameter int bitwidth         = default_bitwidth,
   parameter int N                = default_n,
   parameter int log2_of_max_rate = default_log2_max_rate
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [rate_width-1:0] rate,
   input  logic                  strobe_in,
   input  logic [bitwidth-1:0]   signal_in,
   output logic                  strobe_out,
   output logic [bitwidth-1:0]   signal_out
);

   localparam int acc_width = bitwidth + N * log2_of_max_rate;

   logic                  clear;
   logic [acc_width-1:0]  signal_ext;
   logic [acc_width-1:0]  integ [N];
   logic [acc_width-1:0]  comb [N];
   logic [N-1:0]          comb_stb;
   logic [rate_width-1:0] sample_cnt;
   logic                  fire;
   logic                  dec_strobe;
   logic [bitwidth-1:0]   shifted;

   assign clear      = reset | ~enable;
   assign signal_ext = {{(acc_width - bitwidth){signal_in[bitwidth-1]}}, signal_in};
   assign fire       = strobe_in & (sample_cnt == '0);

   // Terminal count at 0: reload picks up the current rate, so rate changes land at the next reload.
   always_ff @(posedge clock) begin
      if (clear) begin
         sample_cnt <= '0;
         dec_strobe <= 1'b0;
      end else begin
         dec_strobe <= fire;
         if (strobe_in) begin
            if (sample_cnt == '0) sample_cnt <= rate - 8'd1;
            else                  sample_cnt <= sample_cnt - 8'd1;
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_integ
      logic [acc_width-1:0] integ_src;
      logic [acc_width-1:0] acc_q;

      if (k == 0) begin : g_first
         assign integ_src = signal_ext;
      end else begin : g_next
         assign integ_src = integ[k-1];
      end

      always_ff @(posedge clock) begin
         if (clear)          acc_q <= '0;
         else if (strobe_in) acc_q <= acc_q + integ_src;
      end

      assign integ[k] = acc_q;
   end

   // Stage 0 reads the last integrator in the cycle after the firing strobe_in.
   for (genvar k = 0; k < N; k++) begin : g_comb
      logic [acc_width-1:0] comb_in;
      logic                 comb_en;
      logic [acc_width-1:0] delay_q;
      logic [acc_width-1:0] diff_q;
      logic                 stb_q;

      if (k == 0) begin : g_first
         assign comb_in = integ[N-1];
         assign comb_en = dec_strobe;
      end else begin : g_next
         assign comb_in = comb[k-1];
         assign comb_en = comb_stb[k-1];
      end

      always_ff @(posedge clock) begin
         if (clear) begin
            delay_q <= '0;
            diff_q  <= '0;
            stb_q   <= 1'b0;
         end else begin
            stb_q <= comb_en;
            if (comb_en) begin
               diff_q  <= comb_in - delay_q;
               delay_q <= comb_in;
            end
         end
      end

      assign comb[k]     = diff_q;
      assign comb_stb[k] = stb_q;
   end

   cic_dec_shifter #(
      .bitwidth  (bitwidth),
      .N         (N),
      .acc_width (acc_width)
   ) u_shifter (
      .rate      (rate),
      .acc_value (comb[N-1]),
      .result    (shifted)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         strobe_out <= 1'b0;
         signal_out <= '0;
      end else begin
         strobe_out <= comb_stb[N-1];
         if (comb_stb[N-1]) signal_out <= shifted;
      end
   end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: sample-level CIC reference model plus directed and random scenarios.
module tb_cic_decimator;

   localparam int bw = 16;
   localparam int ns = 4;
   localparam int aw = bw + ns * 7;

   logic          clock;
   logic          reset;
   logic          enable;
   logic [7:0]    rate;
   logic          strobe_in;
   logic [bw-1:0] signal_in;
   logic          strobe_out;
   logic [bw-1:0] signal_out;

   cic_decimator #(
      .bitwidth         (bw),
      .N                (ns),
      .log2_of_max_rate (7)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .rate       (rate),
      .strobe_in  (strobe_in),
      .signal_in  (signal_in),
      .strobe_out (strobe_out),
      .signal_out (signal_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int            due;
      logic [aw-1:0] comb;
   } pend_t;

   logic [aw-1:0] m_integ [ns];
   logic [aw-1:0] m_delay [ns];
   int            m_since;
   int            m_per;
   pend_t         pend_q[$];
   logic [bw-1:0] m_out;

   int cyc;
   int errors;
   int checks;
   int pulse_cnt;
   int pulse_cyc[$];

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [bw-1:0] gain_comp(input logic [aw-1:0] c, input logic [7:0] r);
      int    s;
      longint v;
      s = ns * $clog2(int'(r));
      v = longint'($signed(c));
      v = v >>> s;
      return bw'(v);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < ns; k++) begin
         m_integ[k] = '0;
         m_delay[k] = '0;
      end
      m_since = 0;
      m_per   = 1;
      pend_q.delete();
      m_out   = '0;
   endtask

   task automatic model_strobe(input logic [bw-1:0] din);
      logic [aw-1:0] x;
      logic [aw-1:0] v;
      logic [aw-1:0] d;
      pend_t         p;
      x = {{(aw - bw){din[bw-1]}}, din};
      for (int k = ns - 1; k >= 1; k--) m_integ[k] = m_integ[k] + m_integ[k-1];
      m_integ[0] = m_integ[0] + x;
      m_since++;
      if (m_since >= m_per) begin
         m_since = 0;
         m_per   = int'(rate);
         v = m_integ[ns-1];
         for (int k = 0; k < ns; k++) begin
            d          = v - m_delay[k];
            m_delay[k] = v;
            v          = d;
         end
         p.due  = cyc + ns + 2;
         p.comb = v;
         pend_q.push_back(p);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare outputs after the edge.
   task automatic tick(input logic rst, input logic en, input logic stb, input logic [bw-1:0] din);
      logic [7:0] rate_used;
      logic       exp_stb;
      reset     = rst;
      enable    = en;
      strobe_in = stb;
      signal_in = din;
      if (rst || !en) model_reset();
      else if (stb)   model_strobe(din);
      rate_used = rate;
      @(posedge clock);
      #1;
      cyc++;
      exp_stb = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      if (exp_stb) begin
         m_out = gain_comp(pend_q[0].comb, rate_used);
         void'(pend_q.pop_front());
      end
      chk("strobe_out", {63'd0, strobe_out}, {63'd0, exp_stb});
      chk("signal_out", $signed(signal_out), $signed(m_out));
      if (strobe_out) begin
         pulse_cnt++;
         pulse_cyc.push_back(cyc);
      end
   endtask

   task automatic clear_dut();
      tick(1'b1, 1'b1, 1'b0, '0);
      pulse_cnt = 0;
      pulse_cyc.delete();
   endtask

   task automatic run_const(input logic [7:0] r, input logic [bw-1:0] val, input int n_strobes, input int gap);
      clear_dut();
      rate = r;
      for (int i = 0; i < n_strobes; i++) begin
         tick(1'b0, 1'b1, 1'b1, val);
         repeat (gap) tick(1'b0, 1'b1, 1'b0, '0);
      end
      repeat (ns + 3) tick(1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic midstream_clear(input logic use_reset, input string tag);
      int rel;
      clear_dut();
      rate = 8'd4;
      repeat (10) tick(1'b0, 1'b1, 1'b1, 16'd1000);
      if (use_reset) tick(1'b1, 1'b1, 1'b1, 16'd1000);
      else           tick(1'b0, 1'b0, 1'b1, 16'd1000);
      chk({tag, "_out_zero"}, $signed(signal_out), 0);
      chk({tag, "_stb_zero"}, {63'd0, strobe_out}, 0);
      pulse_cnt = 0;
      pulse_cyc.delete();
      rel = cyc;
      tick(1'b0, 1'b1, 1'b1, 16'd1000);
      repeat (ns + 3) tick(1'b0, 1'b1, 1'b0, '0);
      chk({tag, "_refire_cnt"}, pulse_cnt, 1);
      if (pulse_cyc.size() > 0) chk({tag, "_refire_lat"}, pulse_cyc[0], rel + ns + 2);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      cyc       = 0;
      pulse_cnt = 0;
      reset     = 1'b1;
      enable    = 1'b1;
      rate      = 8'd4;
      strobe_in = 1'b0;
      signal_in = '0;
      model_reset();

      clear_dut();
      tick(1'b1, 1'b1, 1'b1, 16'd77);
      chk("reset_out", $signed(signal_out), 0);
      chk("reset_stb", {63'd0, strobe_out}, 0);

      run_const(8'd4, 16'd1000, 64, 0);
      chk("r4_settled", $signed(signal_out), 1000);
      chk("r4_pulses", pulse_cnt, 16);

      run_const(8'd5, 16'd1000, 40, 0);
      chk("r5_settled", $signed(signal_out), 152);
      chk("r5_pulses", pulse_cnt, 8);

      run_const(8'd128, 16'd1000, 768, 0);
      chk("r128_settled", $signed(signal_out), 1000);
      chk("r128_pulses", pulse_cnt, 6);

      run_const(8'd128, 16'h8000, 768, 0);
      chk("r128_neg_full", $signed(signal_out), -32768);

      run_const(8'd1, 16'hFC18, 12, 0);
      chk("r1_passthru", $signed(signal_out), -1000);
      chk("r1_pulses", pulse_cnt, 12);

      run_const(8'd8, 16'd300, 64, 1);
      chk("r8_alt_pulses", pulse_cnt, 8);
      chk("r8_alt_settled", $signed(signal_out), 300);

      // 4 -> 8 after two strobes of the first period: fires at strobes 0, 4, 12, 20, 28
      clear_dut();
      rate = 8'd4;
      repeat (2) tick(1'b0, 1'b1, 1'b1, 16'd500);
      rate = 8'd8;
      repeat (30) tick(1'b0, 1'b1, 1'b1, 16'd500);
      repeat (ns + 3) tick(1'b0, 1'b1, 1'b0, '0);
      chk("rate_chg_pulses", pulse_cnt, 5);
      if (pulse_cyc.size() >= 3) begin
         chk("rate_chg_gap1", pulse_cyc[1] - pulse_cyc[0], 4);
         chk("rate_chg_gap2", pulse_cyc[2] - pulse_cyc[1], 8);
      end

      midstream_clear(1'b1, "mid_reset");
      midstream_clear(1'b0, "mid_enable");

      clear_dut();
      for (int i = 0; i < 3000; i++) begin
         logic r_rst;
         logic r_en;
         logic r_stb;
         if (i % 250 == 0) rate = ($urandom_range(0, 7) == 0) ? 8'd128 : 8'($urandom_range(1, 12));
         r_rst = ($urandom_range(0, 399) == 0);
         r_en  = ($urandom_range(0, 299) != 0);
         r_stb = ($urandom_range(0, 3) != 0);
         tick(r_rst, r_en, r_stb, bw'($urandom));
      end
      repeat (ns + 3) tick(1'b0, 1'b1, 1'b0, '0);
      chk("rand_activity", {63'd0, (pulse_cnt > 0)}, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
